// File: rtl/uart_rx_if.sv
// Byte-level receive interface between uart_rx and its consumer.
// The receiver is the master (drives data/status); the consumer drives ready.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data, valid, busy, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, busy, frame_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-FF synchroniser, 3-sample majority vote,
// framing-error and overrun detection, valid/ready byte output.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    uart_rx_if.master bus
);
    localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
    localparam int CNT_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OS_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic             s7_q, s7_d;
    logic             s8_q, s8_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_sr_q, data_sr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic rx_s;
    logic tick;
    logic eval;
    logic vote;

    assign rx_s = sync2_q;
    assign tick = (cnt_q == CNT_MAX);
    // Third vote sample is the live rx_s on the tick that takes phase to 9.
    assign eval = tick && (phase_q == 4'd8);
    assign vote = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx;
        sync2_d     = sync1_q;
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        bit_idx_d   = bit_idx_q;
        data_sr_d   = data_sr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (tick) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'd6) s7_d = rx_s;
            if (phase_q == 4'd7) s8_d = rx_s;
        end

        if (valid_q && bus.ready) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    phase_d = 4'd0;
                end
            end
            S_START: begin
                if (eval) begin
                    if (vote) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (eval) begin
                    data_sr_d[bit_idx_q] = vote;
                    bit_idx_d            = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (eval) begin
                    if (vote) begin
                        state_d = S_IDLE;
                        // A byte accepted on this same edge frees the slot.
                        if (!valid_q || bus.ready) begin
                            data_d  = data_sr_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            phase_q     <= 4'd0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            bit_idx_q   <= 3'd0;
            data_sr_q   <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            bit_idx_q   <= bit_idx_d;
            data_sr_q   <= data_sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: byte table, glitch, framing error, overrun,
// back-to-back frames at baud offsets, and reset in mid-frame.
module tb_uart_rx;
    // Clock chosen so one oversample tick is 8 clk and a bit is exactly 128 clk.
    localparam int CLK_FREQ_TB = 14_745_600;
    localparam int BAUD_TB     = 115_200;
    localparam int BIT         = 128;
    localparam int BIT_FAST    = 125;
    localparam int BIT_SLOW    = 131;

    logic clk = 1'b0;
    logic rst;
    logic rx_r;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ(CLK_FREQ_TB),
        .BAUD    (BAUD_TB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx_r),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         bclk;
        int         exp_valid;
        int         exp_pop;
        int         exp_fe;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    int valid_cycles = 0;
    int fe_cnt       = 0;
    int ov_cnt       = 0;
    int both_cnt     = 0;
    int busy_cycles  = 0;
    int pop_cnt      = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock of monitoring; outputs sampled on the falling edge. An accept
    // happened on the preceding rising edge if valid was seen high before it
    // and ready has been held since.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            if (prev_valid && bus.ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", prev_data);
                end else begin
                    chk("byte", prev_data, exp_q.pop_front());
                end
            end
            if (bus.valid) valid_cycles++;
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if (bus.frame_err && bus.overrun) both_cnt++;
            if (bus.busy) busy_cycles++;
        end
        prev_valid = bus.valid;
        prev_data  = bus.data;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic v, input int n);
        rx_r = v;
        idle(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bclk, input int stop_low_bits);
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(b[i], bclk);
        if (stop_low_bits > 0) begin
            drive(1'b0, stop_low_bits * bclk);
            chk("busy_in_break", bus.busy, 1);
        end
        drive(1'b1, bclk);
    endtask

    initial begin
        vec_t vecs[5];
        int b_valid, b_fe, b_ov, b_busy, b_pop;
        logic [7:0] v77;

        vecs[0] = '{8'hA5, BIT, 1, 1, 0};
        vecs[1] = '{8'h00, BIT, 1, 1, 0};
        vecs[2] = '{8'hFF, BIT, 1, 1, 0};
        vecs[3] = '{8'h01, BIT, 1, 1, 0};
        vecs[4] = '{8'h80, BIT, 1, 1, 0};

        rst       = 1'b0;
        rx_r      = 1'b1;
        bus.ready = 1'b0;
        idle(5);
        chk("rst_data", bus.data, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b1;
        idle(2 * BIT);
        chk("idle_busy", bus.busy, 0);

        // Single bytes with ready held high
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_valid = valid_cycles; b_fe = fe_cnt; b_busy = busy_cycles; b_pop = pop_cnt;
            exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].bclk, 0);
            idle(BIT);
            chk("tbl_valid_pulse", valid_cycles - b_valid, vecs[i].exp_valid);
            chk("tbl_pop", pop_cnt - b_pop, vecs[i].exp_pop);
            chk("tbl_data", bus.data, vecs[i].data);
            chk("tbl_frame_err", fe_cnt - b_fe, vecs[i].exp_fe);
            chk_range("tbl_busy_len", busy_cycles - b_busy, 9 * BIT, 10 * BIT);
        end

        // Short low glitch on an idle line
        b_valid = valid_cycles; b_fe = fe_cnt; b_busy = busy_cycles;
        drive(1'b0, 40);
        drive(1'b1, BIT);
        chk("glitch_busy_end", bus.busy, 0);
        chk_range("glitch_busy_len", busy_cycles - b_busy, 40, BIT);
        chk("glitch_valid", valid_cycles - b_valid, 0);
        chk("glitch_frame_err", fe_cnt - b_fe, 0);

        // Stop bit held low for two bit periods, then a good byte
        b_valid = valid_cycles; b_fe = fe_cnt; b_pop = pop_cnt;
        send_frame(8'h3C, BIT, 2);
        idle(BIT);
        chk("fe_busy_end", bus.busy, 0);
        chk("fe_count", fe_cnt - b_fe, 1);
        chk("fe_valid", valid_cycles - b_valid, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, BIT, 0);
        idle(BIT);
        chk("fe_next_pop", pop_cnt - b_pop, 1);
        chk("fe_next_data", bus.data, 8'h5A);

        // Overrun with the consumer stalled
        bus.ready = 1'b0;
        b_ov = ov_cnt; b_fe = fe_cnt; b_pop = pop_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, BIT, 0);
        send_frame(8'h22, BIT, 0);
        idle(BIT);
        chk("ovr_valid_held", bus.valid, 1);
        chk("ovr_data_held", bus.data, 8'h11);
        chk("ovr_count", ov_cnt - b_ov, 1);
        chk("ovr_frame_err", fe_cnt - b_fe, 0);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        idle(3);
        chk("ovr_valid_fall", bus.valid, 0);
        chk("ovr_data_after", bus.data, 8'h11);
        chk("ovr_pop", pop_cnt - b_pop, 1);

        // Back-to-back frames at fast and slow line rates
        bus.ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int bclk;
            bclk = (k == 0) ? BIT_FAST : BIT_SLOW;
            b_fe = fe_cnt; b_ov = ov_cnt; b_pop = pop_cnt;
            exp_q.push_back(8'h12);
            exp_q.push_back(8'h34);
            exp_q.push_back(8'h56);
            send_frame(8'h12, bclk, 0);
            send_frame(8'h34, bclk, 0);
            send_frame(8'h56, bclk, 0);
            idle(2 * BIT);
            chk("b2b_pop", pop_cnt - b_pop, 3);
            chk("b2b_frame_err", fe_cnt - b_fe, 0);
            chk("b2b_overrun", ov_cnt - b_ov, 0);
            chk("b2b_queue_empty", exp_q.size(), 0);
        end

        // Reset during bit 4 of 0x77
        v77 = 8'h77;
        b_pop = pop_cnt;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(v77[i], BIT);
        drive(v77[4], BIT / 2);
        rst = 1'b0;
        idle(3);
        chk("midrst_data", bus.data, 0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_frame_err", bus.frame_err, 0);
        chk("midrst_overrun", bus.overrun, 0);
        rx_r = 1'b1;
        idle(BIT);
        rst = 1'b1;
        idle(2 * BIT);
        chk("midrst_no_byte", pop_cnt - b_pop, 0);
        exp_q.push_back(8'h99);
        send_frame(8'h99, BIT, 0);
        idle(BIT);
        chk("midrst_next_pop", pop_cnt - b_pop, 1);
        chk("midrst_next_data", bus.data, 8'h99);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("fe_ovr_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
